// File: rtl/car_drive_controller.sv
// -----------------------------------------------------------------------------
// car_drive_controller
//
// Per-frame driving controller for the player car. Turns keypad commands into
// one-cycle steer pulses for the horizontal car mover and a scroll speed for
// the road/obstacle scrollers, and sequences crash behaviour
// (SPIN -> RECOVER -> DRIVE).
//
// All state, speed and counter updates happen only on clk edges where
// startOfFrame=1 (a "tick"). Outputs are registered, so they change the cycle
// after the tick. The steer pulses last exactly that one cycle.
//
// Optional feature macro: SPIN_WOBBLE_EN
//   defined   : each SPIN tick emits a steer pulse alternating R, L, R, ...
//               (starting with R), which shows as a skid wobble.
//   undefined : no steer pulses during SPIN, and no wobble logic is built.
//
// Parameters:
//   SPEED_MAX      top speed (must not exceed 15)
//   ACCEL_FRAMES   ticks of held accelerate key per +1 speed
//   COAST_FRAMES   ticks without accelerate/brake per -1 speed
//   SPIN_FRAMES    ticks spent in SPIN after a crash
//   RECOVER_FRAMES ticks spent in RECOVER at speed 1
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   startOfFrame   one-clk pulse per video frame
//   keypad[3:0]    key code: 4=left, 6=right, 2=accelerate, 8=brake
//   keypadIsvalid  keypad code valid (level)
//   collision      car/obstacle hit, any cycle
//   EdgeColN       active-low road-edge hit (counts only while driving)
//   steerLeft      one-clk pulse: move car left one step
//   steerRight     one-clk pulse: move car right one step
//   speed[3:0]     current scroll speed, 0..SPEED_MAX
//   state[1:0]     0=IDLE, 1=DRIVE, 2=SPIN, 3=RECOVER
//   crashCount[7:0] saturating crash counter
// -----------------------------------------------------------------------------
module car_drive_controller #(
    parameter int SPEED_MAX      = 8,
    parameter int ACCEL_FRAMES   = 4,
    parameter int COAST_FRAMES   = 8,
    parameter int SPIN_FRAMES    = 32,
    parameter int RECOVER_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic [3:0] keypad,
    input  logic       keypadIsvalid,
    input  logic       collision,
    input  logic       EdgeColN,
    output logic       steerLeft,
    output logic       steerRight,
    output logic [3:0] speed,
    output logic [1:0] state,
    output logic [7:0] crashCount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_SPIN    = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam int ACCEL_W   = $clog2(ACCEL_FRAMES + 1);
    localparam int COAST_W   = $clog2(COAST_FRAMES + 1);
    localparam int SPIN_W    = $clog2(SPIN_FRAMES + 1);
    localparam int RECOVER_W = $clog2(RECOVER_FRAMES + 1);

    localparam logic [3:0] SPEED_TOP = 4'(SPEED_MAX);

    state_e                 state_q,       state_d;
    logic [3:0]             speed_q,       speed_d;
    logic [ACCEL_W-1:0]     accel_cnt_q,   accel_cnt_d;
    logic [COAST_W-1:0]     coast_cnt_q,   coast_cnt_d;
    logic [SPIN_W-1:0]      spin_cnt_q,    spin_cnt_d;
    logic [RECOVER_W-1:0]   recover_cnt_q, recover_cnt_d;
    logic [7:0]             crash_cnt_q,   crash_cnt_d;
    logic                   crash_q,       crash_d;
    logic                   steer_left_q,  steer_left_d;
    logic                   steer_right_q, steer_right_d;
`ifdef SPIN_WOBBLE_EN
    // 0 -> next SPIN tick steers right, 1 -> next SPIN tick steers left.
    logic                   wobble_q,      wobble_d;
`endif

    // Key decode (only meaningful while the code is valid).
    logic key_left, key_right, key_accel, key_brake;
    assign key_left  = keypadIsvalid && (keypad == 4'd4);
    assign key_right = keypadIsvalid && (keypad == 4'd6);
    assign key_accel = keypadIsvalid && (keypad == 4'd2);
    assign key_brake = keypadIsvalid && (keypad == 4'd8);

    // A crash this cycle; road-edge hits only count while actually driving.
    logic crash_event, crash_pending, crash_armed;
    assign crash_event   = collision || (!EdgeColN && (state_q == ST_DRIVE));
    // Including this cycle's event lets a hit coincident with the tick be
    // consumed by that same tick.
    assign crash_pending = crash_q || crash_event;
    // The latch is only meaningful where a crash can be acted on; it is held
    // clear while parked and while already spinning.
    assign crash_armed   = (state_q == ST_DRIVE) || (state_q == ST_RECOVER);

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        speed_d       = speed_q;
        accel_cnt_d   = accel_cnt_q;
        coast_cnt_d   = coast_cnt_q;
        spin_cnt_d    = spin_cnt_q;
        recover_cnt_d = recover_cnt_q;
        crash_cnt_d   = crash_cnt_q;
        steer_left_d  = 1'b0;
        steer_right_d = 1'b0;
        // Ticks consume the latch; in between it accumulates hits.
        crash_d       = crash_armed && crash_pending && !startOfFrame;
`ifdef SPIN_WOBBLE_EN
        wobble_d      = wobble_q;
`endif

        if (startOfFrame) begin
            // Crash handling is shared by DRIVE and RECOVER.
            if (crash_armed && crash_pending) begin
                state_d     = ST_SPIN;
                speed_d     = 4'd0;
                spin_cnt_d  = '0;
                accel_cnt_d = '0;
                coast_cnt_d = '0;
                if (crash_cnt_q != 8'hFF) crash_cnt_d = crash_cnt_q + 8'd1;
`ifdef SPIN_WOBBLE_EN
                wobble_d    = 1'b0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        speed_d = 4'd0;
                        if (key_accel) begin
                            state_d     = ST_DRIVE;
                            speed_d     = 4'd1;
                            accel_cnt_d = '0;
                            coast_cnt_d = '0;
                        end
                    end

                    ST_DRIVE: begin
                        steer_left_d  = key_left;
                        steer_right_d = key_right;
                        if (key_accel) begin
                            coast_cnt_d = '0;
                            if (accel_cnt_q + ACCEL_W'(1) == ACCEL_W'(ACCEL_FRAMES)) begin
                                accel_cnt_d = '0;
                                if (speed_q != SPEED_TOP) speed_d = speed_q + 4'd1;
                            end else begin
                                accel_cnt_d = accel_cnt_q + ACCEL_W'(1);
                            end
                        end else if (key_brake) begin
                            accel_cnt_d = '0;
                            coast_cnt_d = '0;
                            if (speed_q != 4'd0) speed_d = speed_q - 4'd1;
                        end else begin
                            if (coast_cnt_q + COAST_W'(1) == COAST_W'(COAST_FRAMES)) begin
                                coast_cnt_d = '0;
                                if (speed_q != 4'd0) speed_d = speed_q - 4'd1;
                            end else begin
                                coast_cnt_d = coast_cnt_q + COAST_W'(1);
                            end
                        end
                        // Stalling parks the car on the same tick.
                        if (speed_d == 4'd0) state_d = ST_IDLE;
                    end

                    ST_SPIN: begin
                        speed_d    = 4'd0;
                        spin_cnt_d = spin_cnt_q + SPIN_W'(1);
`ifdef SPIN_WOBBLE_EN
                        steer_right_d = !wobble_q;
                        steer_left_d  = wobble_q;
                        wobble_d      = !wobble_q;
`endif
                        if (spin_cnt_q + SPIN_W'(1) == SPIN_W'(SPIN_FRAMES)) begin
                            state_d       = ST_RECOVER;
                            speed_d       = 4'd1;
                            spin_cnt_d    = '0;
                            recover_cnt_d = '0;
                        end
                    end

                    ST_RECOVER: begin
                        speed_d       = 4'd1;
                        steer_left_d  = key_left;
                        steer_right_d = key_right;
                        recover_cnt_d = recover_cnt_q + RECOVER_W'(1);
                        if (recover_cnt_q + RECOVER_W'(1) == RECOVER_W'(RECOVER_FRAMES)) begin
                            state_d       = ST_DRIVE;
                            recover_cnt_d = '0;
                            accel_cnt_d   = '0;
                            coast_cnt_d   = '0;
                        end
                    end

                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            speed_q       <= 4'd0;
            accel_cnt_q   <= '0;
            coast_cnt_q   <= '0;
            spin_cnt_q    <= '0;
            recover_cnt_q <= '0;
            crash_cnt_q   <= 8'd0;
            crash_q       <= 1'b0;
            steer_left_q  <= 1'b0;
            steer_right_q <= 1'b0;
`ifdef SPIN_WOBBLE_EN
            wobble_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            speed_q       <= speed_d;
            accel_cnt_q   <= accel_cnt_d;
            coast_cnt_q   <= coast_cnt_d;
            spin_cnt_q    <= spin_cnt_d;
            recover_cnt_q <= recover_cnt_d;
            crash_cnt_q   <= crash_cnt_d;
            crash_q       <= crash_d;
            steer_left_q  <= steer_left_d;
            steer_right_q <= steer_right_d;
`ifdef SPIN_WOBBLE_EN
            wobble_q      <= wobble_d;
`endif
        end
    end

    assign steerLeft  = steer_left_q;
    assign steerRight = steer_right_q;
    assign speed      = speed_q;
    assign state      = state_q;
    assign crashCount = crash_cnt_q;

endmodule

// File: tb/tb_car_drive_controller.sv
// -----------------------------------------------------------------------------
// tb_car_drive_controller
//
// Directed self-checking bench for car_drive_controller with default
// parameters (SPEED_MAX=8, ACCEL=4, COAST=8, SPIN=32, RECOVER=16).
// A frame tick is one cycle of startOfFrame; outputs are sampled on the
// falling edge after the tick's rising edge.
// -----------------------------------------------------------------------------
module tb_car_drive_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic [3:0] keypad;
    logic       keypadIsvalid;
    logic       collision;
    logic       EdgeColN;
    logic       steerLeft;
    logic       steerRight;
    logic [3:0] speed;
    logic [1:0] state;
    logic [7:0] crashCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    car_drive_controller dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .keypad        (keypad),
        .keypadIsvalid (keypadIsvalid),
        .collision     (collision),
        .EdgeColN      (EdgeColN),
        .steerLeft     (steerLeft),
        .steerRight    (steerRight),
        .speed         (speed),
        .state         (state),
        .crashCount    (crashCount)
    );

    // ---------------------------------------------------------------- stimulus
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_key(input logic [3:0] k, input logic v);
        keypad        = k;
        keypadIsvalid = v;
    endtask

    // One frame tick; returns on the falling edge where the results are visible.
    task automatic tick();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    // Tick with a collision on the very same clock.
    task automatic tick_col();
        @(negedge clk);
        startOfFrame = 1'b1;
        collision    = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
    endtask

    // One-cycle collision between ticks.
    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    task automatic pulse_edge();
        @(negedge clk);
        EdgeColN = 1'b0;
        @(negedge clk);
        EdgeColN = 1'b1;
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        checks++; if (crashCount !== 8'd0) begin errors++; $display("FAIL reset_crash: got %0d expected 0", crashCount); end
        checks++; if ({steerLeft, steerRight} !== 2'b00) begin errors++; $display("FAIL reset_steer: got %b expected 00", {steerLeft, steerRight}); end
    endtask

    task automatic test_accel();
        do_reset();
        set_key(4'd2, 1'b1);
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL start_speed: got %0d expected 1", speed); end
        repeat (27) tick();
        checks++; if (speed !== 4'd7) begin errors++; $display("FAIL accel_27: got %0d expected 7", speed); end
        tick();
        checks++; if (speed !== 4'd8) begin errors++; $display("FAIL accel_28: got %0d expected 8", speed); end
        repeat (8) tick();
        checks++; if (speed !== 4'd8) begin errors++; $display("FAIL accel_sat: got %0d expected 8", speed); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL accel_state: got %0d expected 1", state); end
        set_key(4'd0, 1'b0);
    endtask

    task automatic test_brake();
        do_reset();
        set_key(4'd2, 1'b1);
        tick();
        repeat (8) tick();
        checks++; if (speed !== 4'd3) begin errors++; $display("FAIL brake_pre: got %0d expected 3", speed); end
        set_key(4'd8, 1'b1);
        repeat (2) tick();
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL brake_2: got %0d expected 1", speed); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL brake_2_state: got %0d expected 1", state); end
        tick();
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL brake_stop: got %0d expected 0", speed); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL brake_idle: got %0d expected 0", state); end
        set_key(4'd0, 1'b0);
    endtask

    task automatic test_coast();
        int pulses;
        pulses = 0;
        do_reset();
        set_key(4'd2, 1'b1);
        tick();
        repeat (4) tick();
        checks++; if (speed !== 4'd2) begin errors++; $display("FAIL coast_pre: got %0d expected 2", speed); end
        set_key(4'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            pulses += int'(steerLeft) + int'(steerRight);
        end
        checks++; if (speed !== 4'd2) begin errors++; $display("FAIL coast_7: got %0d expected 2", speed); end
        tick();
        pulses += int'(steerLeft) + int'(steerRight);
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL coast_8: got %0d expected 1", speed); end
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(steerLeft) + int'(steerRight);
        end
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL coast_16: got %0d expected 0", speed); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL coast_idle: got %0d expected 0", state); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL coast_steer: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_steer();
        do_reset();
        set_key(4'd2, 1'b1);
        tick();
        repeat (4) tick();
        set_key(4'd4, 1'b1);
        tick();
        checks++; if ({steerLeft, steerRight} !== 2'b10) begin errors++; $display("FAIL steer_left: got %b expected 10", {steerLeft, steerRight}); end
        @(negedge clk);
        checks++; if (steerLeft !== 1'b0) begin errors++; $display("FAIL steer_left_len: got %b expected 0", steerLeft); end
        set_key(4'd6, 1'b1);
        tick();
        checks++; if ({steerLeft, steerRight} !== 2'b01) begin errors++; $display("FAIL steer_right: got %b expected 01", {steerLeft, steerRight}); end
        @(negedge clk);
        checks++; if (steerRight !== 1'b0) begin errors++; $display("FAIL steer_right_len: got %b expected 0", steerRight); end
        set_key(4'd4, 1'b0);
        tick();
        checks++; if ({steerLeft, steerRight} !== 2'b00) begin errors++; $display("FAIL steer_invalid: got %b expected 00", {steerLeft, steerRight}); end
        checks++; if (speed !== 4'd2) begin errors++; $display("FAIL steer_speed: got %0d expected 2", speed); end
        set_key(4'd0, 1'b0);
    endtask

    task automatic test_crash();
        logic exp_r, exp_l;
        do_reset();
        set_key(4'd2, 1'b1);
        tick();
        repeat (16) tick();
        checks++; if (speed !== 4'd5) begin errors++; $display("FAIL crash_pre: got %0d expected 5", speed); end
        set_key(4'd6, 1'b1);
        pulse_collision();
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_state: got %0d expected 2", state); end
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL crash_speed: got %0d expected 0", speed); end
        checks++; if (crashCount !== 8'd1) begin errors++; $display("FAIL crash_count: got %0d expected 1", crashCount); end
        checks++; if ({steerLeft, steerRight} !== 2'b00) begin errors++; $display("FAIL crash_steer: got %b expected 00", {steerLeft, steerRight}); end
        for (int i = 0; i < 32; i++) begin
            tick();
`ifdef SPIN_WOBBLE_EN
            exp_r = (i % 2 == 0);
            exp_l = (i % 2 == 1);
`else
            exp_r = 1'b0;
            exp_l = 1'b0;
`endif
            checks++; if ({steerLeft, steerRight} !== {exp_l, exp_r}) begin errors++; $display("FAIL spin_steer[%0d]: got %b expected %b", i, {steerLeft, steerRight}, {exp_l, exp_r}); end
            if (i == 10) pulse_collision();
            if (i == 30) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL spin_31: got %0d expected 2", state); end
            end
        end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL recover_state: got %0d expected 3", state); end
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL recover_speed: got %0d expected 1", speed); end
        checks++; if (crashCount !== 8'd1) begin errors++; $display("FAIL spin_ignore_col: got %0d expected 1", crashCount); end
        tick();
        checks++; if (steerRight !== 1'b1) begin errors++; $display("FAIL recover_steer: got %b expected 1", steerRight); end
        set_key(4'd2, 1'b1);
        repeat (14) tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL recover_15: got %0d expected 3", state); end
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL recover_accel_ign: got %0d expected 1", speed); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL recover_done: got %0d expected 1", state); end
        checks++; if (speed !== 4'd1) begin errors++; $display("FAIL recover_done_speed: got %0d expected 1", speed); end
        set_key(4'd0, 1'b0);
    endtask

    task automatic test_edge_crash();
        pulse_edge();
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL edge_state: got %0d expected 2", state); end
        checks++; if (crashCount !== 8'd2) begin errors++; $display("FAIL edge_count: got %0d expected 2", crashCount); end
        repeat (32) tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL edge_recover: got %0d expected 3", state); end
        tick_col();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL recover_col_state: got %0d expected 2", state); end
        checks++; if (crashCount !== 8'd3) begin errors++; $display("FAIL recover_col_count: got %0d expected 3", crashCount); end
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL recover_col_speed: got %0d expected 0", speed); end
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", state); end
        checks++; if (crashCount !== 8'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", crashCount); end
        checks++; if (speed !== 4'd0) begin errors++; $display("FAIL midreset_speed: got %0d expected 0", speed); end
        reset = 1'b0;
        // Road-edge hits while parked must not arm a crash.
        pulse_edge();
        set_key(4'd2, 1'b1);
        tick();
        set_key(4'd0, 1'b0);
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL idle_edge_state: got %0d expected 1", state); end
        checks++; if (crashCount !== 8'd0) begin errors++; $display("FAIL idle_edge_count: got %0d expected 0", crashCount); end
    endtask

    initial begin
        reset         = 1'b1;
        startOfFrame  = 1'b0;
        keypad        = 4'd0;
        keypadIsvalid = 1'b0;
        collision     = 1'b0;
        EdgeColN      = 1'b1;
        test_reset();
        test_accel();
        test_brake();
        test_coast();
        test_steer();
        test_crash();
        test_edge_crash();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_drive_controller.md
Name: car_drive_controller

Overview:
- Per-frame driving controller for the player car.
- Converts keypad commands into one-cycle steer pulses for the horizontal car mover and a scroll speed for the road/obstacle scrollers.
- Sequences crash behaviour: spin-out, recovery, then normal driving.
- Sits between the keypad decoder and the car mover / road scroll logic.

Parameters:
- SPEED_MAX, 8, top speed value; must not exceed 15.
- ACCEL_FRAMES, 4, frames of held accelerate key per +1 speed.
- COAST_FRAMES, 8, frames with no accel/brake per -1 speed.
- SPIN_FRAMES, 32, frames spent in SPIN after a crash.
- RECOVER_FRAMES, 16, frames spent in RECOVER at speed 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-clk pulse per video frame
- keypad  in  4  key code: 4=left, 6=right, 2=accelerate, 8=brake
- keypadIsvalid  in  1  keypad code valid (level)
- collision  in  1  car/obstacle hit, any cycle, level or pulse
- EdgeColN  in  1  active-low road-edge hit from the car mover
- steerLeft  out  1  one-clk pulse: move car left one step
- steerRight  out  1  one-clk pulse: move car right one step
- speed  out  4  current scroll speed, 0..SPEED_MAX
- state  out  2  0=IDLE, 1=DRIVE, 2=SPIN, 3=RECOVER
- crashCount  out  8  saturating crash counter

Behaviour:
- Reset (synchronous, active-high, one clk clock, overrides everything, valid mid-operation):
  - state=IDLE, speed=0, steer outputs=0, crashCount=0, all frame counters=0, crash latch=0.
- Crash latch:
  - Set on any clk with collision=1, or EdgeColN=0 while state=DRIVE.
  - Cleared on the frame tick that consumes it.
  - If collision coincides with startOfFrame, it is consumed in that same tick.
- Frame tick: all state, speed and counter updates occur only on clk edges where startOfFrame=1.
  - Outputs are registered and visible the cycle after the tick.
  - steerLeft/steerRight are high for exactly that one cycle and never both high.
- IDLE:
  - speed=0, no steering.
  - Tick with key 2 valid -> DRIVE, speed=1, accel counter=0.
- DRIVE, evaluated per tick in this priority order:
  1. Crash latch set -> SPIN; speed=0; spin counter=0; crashCount+1, saturating at 255. Keypad ignored that tick.
  2. Key 4 -> steerLeft pulse. Key 6 -> steerRight pulse.
  3. Key 2 -> accel counter+1; at ACCEL_FRAMES it resets and speed+1, saturating at SPEED_MAX.
  4. Key 8 -> speed-1 immediately, saturating at 0; accel counter=0.
  5. Neither key 2 nor key 8 (including keypadIsvalid=0) -> coast counter+1; at COAST_FRAMES it resets and speed-1, floor 0.
  - Speed reaching 0 in DRIVE -> IDLE on the same tick.
- SPIN:
  - speed=0; keypad ignored; new collisions ignored (latch held clear).
  - spin counter+1 per tick; when it reaches SPIN_FRAMES -> RECOVER, recover counter=0.
- RECOVER:
  - speed=1; steering keys honoured; accel/brake ignored.
  - A collision here re-enters SPIN and counts as a crash.
  - After RECOVER_FRAMES ticks -> DRIVE with speed=1 and counters cleared.
- Counter widths: wide enough for the parameter values; no wrap inside any state.

Optional Feature:
- Macro: SPIN_WOBBLE_EN.
- Defined: during SPIN, each tick emits a steer pulse alternating right, left, right, ... starting with right on the first SPIN tick. The mover shows a skid wobble with net zero displacement over an even count.
- Undefined: no steer pulses in SPIN. The wobble toggle logic is absent.

Test Plan:
- Reset -> state=0, speed=0, crashCount=0. Tick with key 2 -> state=1, speed=1. Hold key 2 for 28 further ticks -> speed=8 and stays 8 (saturation).
- DRIVE speed=3, key 8 for 2 ticks -> speed=1. Key 8 once more -> speed=0, state=IDLE.
- DRIVE speed=2, no key for 16 ticks -> speed=0, state=IDLE, no steer pulses.
- DRIVE, key 4 on a tick -> steerLeft high exactly 1 cycle after the tick. Key 6 -> steerRight 1 cycle. keypadIsvalid=0 -> no pulses.
- DRIVE speed=5, collision pulse mid-frame with key 6 held -> next tick state=SPIN, speed=0, crashCount=1, no steerRight. 32 ticks later -> RECOVER, speed=1. 16 ticks later -> DRIVE.
- Reset asserted during SPIN -> next cycle IDLE, crashCount=0. With SPIN_WOBBLE_EN: the first 4 SPIN ticks give steer R, L, R, L.
